dct_coeff_sequencer: RTL and testbench

//  Sequences one 8x8 2-D DCT block through the cosine-term LUT bank and a single shared MAC.
//  For each output coefficient (k1,k2), raster order k1-major:
//   - sweep all 64 pixel positions (n1,n2);
//   - drive the LUT-bank select (k1,k2) and the pixel-buffer read address;
//   - accumulate pixel*cos_term, then round, saturate and emit the coefficient on a valid/ready port.

---
 rtl/dct_coeff_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_dct_coeff_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dct_coeff_sequencer.sv
// dct_coeff_sequencer
// Walks one 8x8 block through a 2-D DCT, one output coefficient at a time.
// For every (k1,k2), raster order k1-major:
//   - sweeps all 64 pixel positions;
//   - drives the LUT select and the pixel RAM address;
//   - accumulates pixel*cos_term through a 3-stage pipeline;
//   - rounds and saturates the sum, then offers it on a valid/ready port.
module dct_coeff_sequencer #(
  parameter int PIX_W      = 8,
  parameter int COS_W      = 32,
  parameter int ACC_W      = 48,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              k1,
  output logic [2:0]              k2,
  output logic [2:0]              n1,
  output logic [2:0]              n2,
  output logic                    pix_rd_en,
  output logic [5:0]              pix_rd_addr,
  input  logic signed [PIX_W-1:0] pix_rd_data,
  input  logic signed [COS_W-1:0] cos_term,
  output logic                    coef_valid,
  input  logic                    coef_ready,
  output logic signed [OUT_W-1:0] coef_data,
  output logic [5:0]              coef_idx
);

  localparam int PROD_W = PIX_W + COS_W;

  // Half an LSB of the output, added before the arithmetic shift.
  localparam logic signed [ACC_W-1:0] RND_CONST = ACC_W'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = -(ACC_W'(1) <<< (OUT_W - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [5:0]              k_reg;       // {k1,k2}
  logic [5:0]              n_reg;       // {n1,n2}
  logic                    drain_reg;   // second DRAIN cycle marker
  logic                    done_reg;

  // Pipeline: stage 1 holds the registered LUT term; stage 2 pairs it with the RAM data.
  logic                    s1_vld_reg;
  logic                    s2_vld_reg;
  logic signed [COS_W-1:0] cos_s1_reg;
  logic signed [COS_W-1:0] cos_s2_reg;
  logic signed [PIX_W-1:0] pix_s2_reg;

  logic signed [ACC_W-1:0] acc_reg;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_rnd;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [OUT_W-1:0]  sat_val;

  logic start_ok;
  logic handshake;

  assign start_ok  = (state_reg == S_IDLE) && start;
  assign handshake = (state_reg == S_OUT) && coef_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE:  if (start) state_next = S_RUN;
        S_RUN:   if (n_reg == 6'd63) state_next = S_DRAIN;
        S_DRAIN: if (drain_reg) state_next = S_OUT;
        S_OUT: begin
          if (coef_ready) begin
            state_next = (k_reg == 6'd63) ? S_IDLE : S_RUN;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Coefficient/pixel counters, drain marker and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg     <= '0;
      n_reg     <= '0;
      drain_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else if (abort) begin
      k_reg     <= '0;
      n_reg     <= '0;
      drain_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (start) begin
            k_reg     <= '0;
            n_reg     <= '0;
            drain_reg <= 1'b0;
          end
        end
        S_RUN: begin
          // n parks at 63 so the LUT select stays put through DRAIN/OUT.
          if (n_reg != 6'd63) n_reg <= n_reg + 6'd1;
        end
        S_DRAIN: begin
          drain_reg <= ~drain_reg;
        end
        S_OUT: begin
          if (coef_ready) begin
            if (k_reg == 6'd63) begin
              done_reg <= 1'b1;
            end else begin
              k_reg <= k_reg + 6'd1;
              n_reg <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // MAC operand pipeline: LUT term at issue, RAM data one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
      cos_s1_reg <= '0;
      cos_s2_reg <= '0;
      pix_s2_reg <= '0;
    end else if (abort) begin
      s1_vld_reg <= 1'b0;
      s2_vld_reg <= 1'b0;
      cos_s1_reg <= '0;
      cos_s2_reg <= '0;
      pix_s2_reg <= '0;
    end else begin
      s1_vld_reg <= (state_reg == S_RUN);
      s2_vld_reg <= s1_vld_reg;
      cos_s1_reg <= cos_term;
      cos_s2_reg <= cos_s1_reg;
      pix_s2_reg <= pix_rd_data;
    end
  end

  // Signed product, sign-extended to the accumulator width.
  always_comb begin
    prod     = pix_s2_reg * cos_s2_reg;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Accumulator: cleared when a coefficient begins, summed while stage 2 is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (abort) begin
      acc_reg <= '0;
    end else if (start_ok || handshake) begin
      acc_reg <= '0;
    end else if (s2_vld_reg) begin
      acc_reg <= acc_reg + prod_ext;
    end
  end

  // Round half-up in fixed point, then clamp to the output range.
  always_comb begin
    acc_rnd = acc_reg + RND_CONST;
    acc_shr = acc_rnd >>> FRAC_SHIFT;
    if (acc_shr > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (acc_shr < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_val = acc_shr[OUT_W-1:0];
    end
  end

  // Moore outputs; coefficient port reads zero outside OUT.
  always_comb begin
    busy       = (state_reg != S_IDLE);
    pix_rd_en  = (state_reg == S_RUN);
    coef_valid = (state_reg == S_OUT);
    coef_data  = '0;
    coef_idx   = '0;
    if (state_reg == S_OUT) begin
      coef_data = sat_val;
      coef_idx  = k_reg;
    end
  end

  assign done        = done_reg;
  assign k1          = k_reg[5:3];
  assign k2          = k_reg[2:0];
  assign n1          = n_reg[5:3];
  assign n2          = n_reg[2:0];
  assign pix_rd_addr = n_reg;

endmodule

// File: tb/tb_dct_coeff_sequencer.sv
// Bench for dct_coeff_sequencer: pixel RAM and LUT bank models, random and
// fixed stimulus, and a direct DCT-sum reference for every coefficient.
module tb_dct_coeff_sequencer;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               coef_ready = 1'b1;
  logic               busy, done, pix_rd_en, coef_valid;
  logic [2:0]         k1, k2, n1, n2;
  logic [5:0]         pix_rd_addr, coef_idx;
  logic signed [7:0]  pix_rd_data = '0;
  logic signed [31:0] cos_term;
  logic signed [15:0] coef_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [7:0] pix_mem [64];
  int                lut_tab [4096];

  wire [43:0] out_vec = {busy, done, k1, k2, n1, n2, pix_rd_en, pix_rd_addr,
                         coef_valid, coef_data, coef_idx};

  always #5 clk = ~clk;

  dct_coeff_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .k1          (k1),
    .k2          (k2),
    .n1          (n1),
    .n2          (n2),
    .pix_rd_en   (pix_rd_en),
    .pix_rd_addr (pix_rd_addr),
    .pix_rd_data (pix_rd_data),
    .cos_term    (cos_term),
    .coef_valid  (coef_valid),
    .coef_ready  (coef_ready),
    .coef_data   (coef_data),
    .coef_idx    (coef_idx)
  );

  // Pixel block RAM with one-cycle registered read.
  always @(posedge clk) begin
    if (pix_rd_en) pix_rd_data <= pix_mem[pix_rd_addr];
  end

  // LUT bank: combinational from the current select and index.
  always_comb cos_term = lut_tab[{k1, k2, n1, n2}];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: X(k) = sat(round(sum_n pix[n]*cos[k][n] / 2^8)).
  function automatic longint exp_coef(input int k);
    longint acc = 0;
    longint r;
    for (int n = 0; n < 64; n++) begin
      acc += longint'(pix_mem[n]) * longint'(lut_tab[k * 64 + n]);
    end
    r = (acc + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic set_lut_const(input int c);
    for (int i = 0; i < 4096; i++) lut_tab[i] = c;
  endtask

  task automatic set_lut_dct();
    for (int i = 0; i < 4096; i++) begin
      real v;
      v = 2048.0 * $cos((2.0 * ((i >> 3) & 7) + 1.0) * ((i >> 9) & 7) * PI / 16.0)
                 * $cos((2.0 * (i & 7) + 1.0) * ((i >> 6) & 7) * PI / 16.0);
      lut_tab[i] = int'(v);
    end
  endtask

  task automatic set_lut_rand();
    for (int i = 0; i < 4096; i++) lut_tab[i] = int'($urandom_range(0, 131072)) - 65536;
  endtask

  task automatic set_pix_const(input int p);
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'(p);
  endtask

  task automatic set_pix_rand();
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Runs one block. stall_n: ready-low cycles at idx 0; start_at: stray start
  // cycle; abort_at: abort cycle; rst_idx: coefficient at which rst_n drops.
  task automatic run_block(input string name, input int stall_n, input int start_at,
                           input int abort_at, input int rst_idx);
    int  cyc = 0;
    int  nout = 0;
    int  stall_cnt = 0;
    bit  fin = 0;
    bit  seen;
    logic signed [15:0] held_data = '0;
    @(negedge clk);
    start      = 1'b1;
    coef_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({name, "_busy"}, longint'(busy), 1);
    while (!fin) begin
      if (done) begin
        check_val({name, "_done_cycle"}, cyc, 4288 + stall_n);
        check_val({name, "_coef_count"}, nout, 64);
        @(negedge clk);
        check_val({name, "_done_pulse"}, longint'(done), 0);
        check_val({name, "_idle_busy"}, longint'(busy), 0);
        fin = 1;
      end else if (cyc > 6000) begin
        check_val({name, "_timeout"}, cyc, 4288 + stall_n);
        fin = 1;
      end else if (abort_at >= 0 && cyc == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val({name, "_abort_outputs"}, longint'(out_vec), 0);
        seen = 0;
        repeat (300) begin
          @(negedge clk);
          if (done || busy) seen = 1;
        end
        check_val({name, "_abort_no_done"}, longint'(seen), 0);
        fin = 1;
      end else if (rst_idx >= 0 && coef_valid && coef_idx == 6'(rst_idx)) begin
        #1 rst_n = 1'b0;
        #1 check_val({name, "_reset_immediate"}, longint'(out_vec), 0);
        @(negedge clk);
        check_val({name, "_reset_held"}, longint'(out_vec), 0);
        rst_n = 1'b1;
        fin = 1;
      end else begin
        start = (cyc == start_at);
        if (coef_valid) begin
          check_val({name, "_no_rd_in_out"}, longint'(pix_rd_en), 0);
          if (coef_idx == 6'd0 && stall_cnt < stall_n) begin
            if (stall_cnt == 0) held_data = coef_data;
            else begin
              check_val({name, "_stall_data"}, longint'(coef_data), longint'(held_data));
              check_val({name, "_stall_idx"}, longint'(coef_idx), 0);
            end
            coef_ready = 1'b0;
            stall_cnt++;
          end else begin
            if (stall_n > 0 && coef_idx == 6'd0)
              check_val({name, "_stall_release"}, longint'(coef_data), longint'(held_data));
            coef_ready = 1'b1;
            check_val({name, "_idx"}, longint'(coef_idx), nout);
            check_val({name, "_data"}, longint'(coef_data), exp_coef(nout));
            $display("%s coef idx=%0d data=%0d exp=%0d", name, coef_idx, coef_data, exp_coef(nout));
            nout++;
          end
        end else begin
          coef_ready = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start      = 1'b0;
    abort      = 1'b0;
    coef_ready = 1'b1;
  endtask

  initial begin
    set_lut_const(0);
    set_pix_const(0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", longint'(out_vec), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_after_reset", longint'(out_vec), 0);

    set_lut_dct();                 set_pix_const(0);   run_block("t1_zero",  0, -1, -1, -1);
    set_lut_const(256);            set_pix_const(1);   run_block("t2_plus",  0, -1, -1, -1);
    set_pix_const(-1);                                 run_block("t3_minus", 0, -1, -1, -1);
    set_lut_const(int'(32'h7FFFFFFF)); set_pix_const(127); run_block("t4_satp", 0, -1, -1, -1);
    set_lut_const(int'(32'h80000000)); set_pix_const(127); run_block("t5_satn", 0, -1, -1, -1);
    set_lut_rand();                set_pix_rand();     run_block("t6_stall", 10, -1, -1, -1);
    set_lut_rand();                set_pix_rand();     run_block("t7_start", 0, 100, -1, -1);
    set_lut_rand();                set_pix_rand();     run_block("t8_abort", 0, -1, 500, -1);
    set_lut_rand();                set_pix_rand();     run_block("t9_after", 0, -1, -1, -1);
    set_lut_rand();                set_pix_rand();     run_block("t10_rst",  0, -1, -1, 5);
    set_lut_rand();                set_pix_rand();     run_block("t11_after", 0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
